// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU; the result is returned on a single tagged response channel.
`timescale 1ns/1ps
module alu_arbiter #(
   parameter int WIDTH      = 32,
   parameter int PRIO_RESET = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [3:0]       req1_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam logic PRIO_BIT = (PRIO_RESET != 0) ? 1'b1 : 1'b0;

   function automatic logic op_supported(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0110: op_supported = 1'b1;
         default:                            op_supported = 1'b0;
      endcase
   endfunction

   state_e           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [3:0]       alu_op_q, alu_op_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_err_q, rsp_err_d;
   logic             busy_q, busy_d;

   logic             grant_valid_s;
   logic             grant_id_s;
   logic             other_s;
   logic [1:0]       req_ready_s;

   assign other_s = ~ptr_q;

   // Pointer requester wins when valid; otherwise the other one if it is valid.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_id_s    = ptr_q;
      if (req_valid[ptr_q]) begin
         grant_valid_s = 1'b1;
         grant_id_s    = ptr_q;
      end else if (req_valid[other_s]) begin
         grant_valid_s = 1'b1;
         grant_id_s    = other_s;
      end else begin
         grant_valid_s = 1'b0;
         grant_id_s    = ptr_q;
      end
   end

   // Ready is only offered in IDLE, and is forced low while reset is asserted.
   always_comb begin
      req_ready_s = 2'b00;
      if ((state_q == ST_IDLE) && grant_valid_s && rst_n) begin
         if (grant_id_s) begin
            req_ready_s = 2'b10;
         end else begin
            req_ready_s = 2'b01;
         end
      end else begin
         req_ready_s = 2'b00;
      end
   end

   // Next-state and datapath capture for the IDLE -> EXEC -> RESP cycle.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid_s) begin
               if (grant_id_s) begin
                  alu_a_d  = req1_a;
                  alu_b_d  = req1_b;
                  alu_op_d = req1_op;
               end else begin
                  alu_a_d  = req0_a;
                  alu_b_d  = req0_b;
                  alu_op_d = req0_op;
               end
               rsp_id_d = grant_id_s;
               state_d  = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_err_d    = ~op_supported(alu_op_q);
            rsp_valid_d  = 1'b1;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               ptr_d       = ~rsp_id_q;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, pointer and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= PRIO_BIT;
         alu_a_q      <= {WIDTH{1'b0}};
         alu_b_q      <= {WIDTH{1'b0}};
         alu_op_q     <= 4'b0000;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= {WIDTH{1'b0}};
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         busy_q       <= busy_d;
      end
   end

   assign req_ready  = req_ready_s;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes expected responses,
// a negedge monitor compares every presented response against the queue head.
`timescale 1ns/1ps
module tb_alu_arbiter;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         v0, v1;
   logic [1:0]   req_valid;
   logic [1:0]   req_ready;
   logic [W-1:0] a0, b0, a1, b1;
   logic [3:0]   op0, op1;
   logic [W-1:0] alu_a, alu_b, alu_result;
   logic [3:0]   alu_op;
   logic         alu_zero;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
   logic [W-1:0] rsp_result;

   typedef struct {
      logic         id;
      logic [W-1:0] res;
      logic         z;
      logic         e;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic prev_v = 1'b0;
   exp_t head;

   assign req_valid = {v1, v0};

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W), .PRIO_RESET(0)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(a0), .req0_b(b0), .req0_op(op0),
      .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
   );

   // Behavioural ALU attached to the arbiter's ALU port.
   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Response monitor: compares, checks latency and stalls, pops on handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         check("ready_not_both", {63'd0, req_ready == 2'b11}, 64'd0);
         if (req_ready != 2'b00) acc_q.push_back(cyc);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
            end else begin
               head = exp_q[0];
               check("rsp_id", {63'd0, rsp_id}, {63'd0, head.id});
               check("rsp_result", {32'd0, rsp_result}, {32'd0, head.res});
               check("rsp_zero", {63'd0, rsp_zero}, {63'd0, head.z});
               check("rsp_err", {63'd0, rsp_err}, {63'd0, head.e});
               check("resp_ready_low", {62'd0, req_ready}, 64'd0);
               check("resp_busy", {63'd0, busy}, 64'd1);
               if (!prev_v) begin
                  if (acc_q.size() == 0) check("latency_no_accept", 64'd1, 64'd0);
                  else check("latency", 64'(cyc - acc_q.pop_front()), 64'd2);
               end
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
         prev_v <= rsp_valid;
      end else begin
         prev_v <= 1'b0;
      end
   end

   task automatic expect_rsp(input logic id, input logic [W-1:0] r, input logic z, input logic e);
      exp_t x;
      x.id = id; x.res = r; x.z = z; x.e = e;
      exp_q.push_back(x);
   endtask

   task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op);
      logic ok;
      ok = 1'b0;
      if (id) begin a1 = a; b1 = b; op1 = op; v1 = 1'b1; end
      else    begin a0 = a; b0 = b; op0 = op; v0 = 1'b1; end
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready[id]) begin ok = 1'b1; break; end
      end
      check("accept_timeout", {63'd0, ok}, 64'd1);
      if (ok) check("grant_onehot", {62'd0, req_ready}, id ? 64'd2 : 64'd1);
      @(posedge clk); #1;
      if (id) v1 = 1'b0; else v0 = 1'b0;
   endtask

   task automatic drain();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("drain_timeout", {63'd0, ok}, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req_ready"}, {62'd0, req_ready}, 64'd0);
      check({tag, "_alu_a"}, {32'd0, alu_a}, 64'd0);
      check({tag, "_alu_b"}, {32'd0, alu_b}, 64'd0);
      check({tag, "_alu_op"}, {60'd0, alu_op}, 64'd0);
      check({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
      check({tag, "_rsp_id"}, {63'd0, rsp_id}, 64'd0);
      check({tag, "_rsp_result"}, {32'd0, rsp_result}, 64'd0);
      check({tag, "_rsp_zero"}, {63'd0, rsp_zero}, 64'd0);
      check({tag, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
      v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
      a0 = '0; b0 = '0; op0 = 4'b0000; a1 = '0; b1 = '0; op1 = 4'b0000;
      #2;
      check_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic ADD from requester 0
      expect_rsp(1'b0, 32'd8, 1'b0, 1'b0);
      issue(1'b0, 32'd5, 32'd3, 4'b0010);
      drain();

      // SUB to zero and ADD wrap from requester 1
      expect_rsp(1'b1, 32'd0, 1'b1, 1'b0);
      issue(1'b1, 32'd7, 32'd7, 4'b0110);
      expect_rsp(1'b1, 32'd0, 1'b1, 1'b0);
      issue(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
      drain();

      // Both requesters continuously valid: grant order 0,1,0,1
      expect_rsp(1'b0, 32'h0000_F000, 1'b0, 1'b0);
      expect_rsp(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
      expect_rsp(1'b0, 32'h0000_F000, 1'b0, 1'b0);
      expect_rsp(1'b1, 32'h0000_00FF, 1'b0, 1'b0);
      fork
         begin
            issue(1'b0, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000);
            issue(1'b0, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000);
         end
         begin
            issue(1'b1, 32'h0000_000F, 32'h0000_00F0, 4'b0001);
            issue(1'b1, 32'h0000_000F, 32'h0000_00F0, 4'b0001);
         end
      join
      drain();

      // Backpressure with a pending requester 1
      rsp_ready = 1'b0;
      expect_rsp(1'b0, 32'd30, 1'b0, 1'b0);
      expect_rsp(1'b1, 32'd7, 1'b0, 1'b0);
      issue(1'b0, 32'd10, 32'd20, 4'b0010);
      a1 = 32'd3; b1 = 32'd4; op1 = 4'b0001; v1 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1'b1; break; end
      end
      check("bp_rsp_valid_timeout", {63'd0, ok}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_valid", {63'd0, rsp_valid}, 64'd1);
         check("bp_no_accept", {62'd0, req_ready}, 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_next_accept", {62'd0, req_ready}, 64'd2);
      @(posedge clk); #1;
      v1 = 1'b0;
      drain();

      // Unsupported opcode then a normal ADD
      expect_rsp(1'b0, 32'd0, 1'b1, 1'b1);
      issue(1'b0, 32'd9, 32'd4, 4'b1111);
      expect_rsp(1'b0, 32'd2, 1'b0, 1'b0);
      issue(1'b0, 32'd1, 32'd1, 4'b0010);
      drain();

      // Reset during EXEC aborts the operation and restores the pointer
      a0 = 32'd100; b0 = 32'd1; op0 = 4'b0010; v0 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[0]) begin ok = 1'b1; break; end
      end
      check("abort_accept_timeout", {63'd0, ok}, 64'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("abort");
      v0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      acc_q.delete();
      repeat (5) @(negedge clk);
      check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
      check("abort_idle", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;

      expect_rsp(1'b0, 32'd5, 1'b0, 1'b0);
      expect_rsp(1'b1, 32'd3, 1'b0, 1'b0);
      fork
         issue(1'b0, 32'd2, 32'd3, 4'b0010);
         issue(1'b1, 32'd6, 32'd3, 4'b0110);
      join
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
